// File: rtl/sign_entry_pkg.sv
// Shared sign-code constants, FSM state encoding and the out-of-range code mapping.
package sign_entry_pkg;

    localparam int                SIGN_W    = 4;
    localparam logic [SIGN_W-1:0] SIGN_MAX  = 4'd8;
    localparam logic [SIGN_W-1:0] SIGN_REST = 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REST,
        WAIT_SIGN
    } entry_state_t;

    // Codes the identifier cannot legally produce are folded onto rest.
    function automatic logic [SIGN_W-1:0] map_sign(input logic [SIGN_W-1:0] code);
        return (code > SIGN_MAX) ? SIGN_REST : code;
    endfunction

endpackage

// File: rtl/sign_entry_sequencer_if.sv
// Committed-symbol stream: head symbol, valid and ready.
interface sign_entry_sequencer_if;
    import sign_entry_pkg::*;

    logic [SIGN_W-1:0] sym_data;
    logic              sym_valid;
    logic              sym_ready;

    modport master (output sym_data, output sym_valid, input  sym_ready);
    modport slave  (input  sym_data, input  sym_valid, output sym_ready);

endinterface

// File: rtl/sign_stability_filter.sv
// Purpose: tracks the current candidate code and how long it has been held unchanged.
// Latency: stable asserts STABLE_CYCLES-1 cycles after cand first takes a value.
// Backpressure: none; clear forces cand back to rest and restarts the count.
module sign_stability_filter #(
    parameter int STABLE_CYCLES = 16,
    parameter int SIGN_W        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [SIGN_W-1:0] sign,
    output logic [SIGN_W-1:0] cand,
    output logic              stable
);

    localparam int              CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cand <= '0;
            cnt  <= '0;
        end else if (sign != cand) begin
            cand <= sign;
            cnt  <= '0;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign stable = (cnt == CNT_MAX);

endmodule

// File: rtl/sign_entry_sequencer.sv
// Purpose: commits each held, rest-separated sign once into a symbol FIFO (optional SIGN_ENTRY_TIMEOUT_EN flush).
// Latency: sym_valid rises STABLE_CYCLES cycles after the sign is first held; head visible same cycle.
// Backpressure: sym_ready stalls the drain; a commit into a full FIFO without a pop is dropped and sets overflow.
module sign_entry_sequencer
    import sign_entry_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 2**24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [SIGN_W-1:0]        sign_in,
    input  logic                     enable,
    sign_entry_sequencer_if.master   sym,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     timeout_pulse
);

    localparam int AW = $clog2(DEPTH);

    if (STABLE_CYCLES < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("sign_entry_sequencer: illegal parameter set");
    end

    entry_state_t      state, state_n;
    logic [SIGN_W-1:0] cand;
    logic              stable;
    logic              push_req;

    sign_stability_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .SIGN_W        (SIGN_W)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .clear  (!enable),
        .sign   (map_sign(sign_in)),
        .cand   (cand),
        .stable (stable)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // A commit needs a stable rest first, so a held sign is entered only once.
    always_comb begin
        state_n  = state;
        push_req = 1'b0;
        if (!enable) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE:      state_n = WAIT_REST;
                WAIT_REST: if (stable && cand == SIGN_REST) state_n = WAIT_SIGN;
                WAIT_SIGN: if (stable && cand != SIGN_REST) begin
                    push_req = 1'b1;
                    state_n  = WAIT_REST;
                end
                default:   state_n = IDLE;
            endcase
        end
    end

    logic [SIGN_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              not_empty, full, pop, flush, wr_en, rd_en, drop;

    assign not_empty = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = not_empty && sym.sym_ready;
    // A same-cycle pop frees the slot the push needs, even when full.
    assign wr_en     = push_req && (!full || pop) && !flush;
    assign rd_en     = pop && !flush;
    assign drop      = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !rd_en)      count <= count + 1'b1;
            else if (!wr_en && rd_en) count <= count - 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    assign sym.sym_valid = not_empty;
    assign sym.sym_data  = not_empty ? mem[rd_ptr] : SIGN_REST;
    assign fifo_count    = count;

`ifdef SIGN_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    logic [TW-1:0] idle_cnt;
    logic          idle_hit;

    assign idle_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign flush    = idle_hit && not_empty;

    // Only commits and leaving the active states count as activity; draining does not.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= flush;
            if (push_req || state_n == IDLE || idle_hit) idle_cnt <= '0;
            else if (state != IDLE)                     idle_cnt <= idle_cnt + 1'b1;
        end
    end
`else
    assign flush         = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_sign_entry_sequencer.sv
// Directed bench for sign_entry_sequencer at STABLE_CYCLES=4, DEPTH=4, TIMEOUT_CYCLES=32.
module tb_sign_entry_sequencer;
    import sign_entry_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sign_in;
    logic       enable;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       timeout_pulse;

    int n_checks = 0;
    int n_errors = 0;

    sign_entry_sequencer_if sym ();

    sign_entry_sequencer #(
        .STABLE_CYCLES  (4),
        .DEPTH          (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sign_in       (sign_in),
        .enable        (enable),
        .sym           (sym),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hold(input logic [3:0] code, input int n);
        sign_in = code;
        cyc(n);
    endtask

    task automatic pop_expect(input string tag, input logic [3:0] exp);
        check({tag, "_valid"}, 32'(sym.sym_valid), 32'd1);
        check({tag, "_data"}, 32'(sym.sym_data), 32'(exp));
        sym.sym_ready = 1'b1;
        cyc(1);
        sym.sym_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(sym.sym_valid), 32'd0);
        check({tag, "_data"}, 32'(sym.sym_data), 32'd0);
        check({tag, "_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_ovf"}, 32'(overflow), 32'd0);
        check({tag, "_tmo"}, 32'(timeout_pulse), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; sign_in = 4'd0; sym.sym_ready = 1'b0;
        cyc(3);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Rest then a held 3: visible the cycle after the filter reports stable.
        enable = 1'b1;
        hold(4'd0, 4);
        hold(4'd3, 4);
        check("t1_latency_valid", 32'(sym.sym_valid), 32'd0);
        hold(4'd3, 1);
        check("t1_valid", 32'(sym.sym_valid), 32'd1);
        check("t1_data", 32'(sym.sym_data), 32'd3);
        check("t1_count", 32'(fifo_count), 32'd1);

        // Long hold commits once; a rest in between allows a repeat.
        hold(4'd3, 99);
        check("t2_hold_count", 32'(fifo_count), 32'd1);
        hold(4'd0, 4);
        hold(4'd3, 4);
        hold(4'd0, 1);
        check("t2_repeat_count", 32'(fifo_count), 32'd2);
        pop_expect("t2_pop0", 4'd3);
        pop_expect("t2_pop1", 4'd3);
        check("t2_empty", 32'(fifo_count), 32'd0);
        hold(4'd0, 4);

        // A glitch restarts the stability count; code 12 behaves as rest.
        hold(4'd5, 3);
        hold(4'd2, 1);
        hold(4'd5, 3);
        check("t3_glitch_count", 32'(fifo_count), 32'd0);
        hold(4'd5, 1);
        check("t3_pre_commit", 32'(fifo_count), 32'd0);
        hold(4'd12, 1);
        check("t3_commit_count", 32'(fifo_count), 32'd1);
        check("t3_commit_data", 32'(sym.sym_data), 32'd5);
        hold(4'd12, 4);
        hold(4'd7, 4);
        hold(4'd12, 1);
        check("t3_rest12_count", 32'(fifo_count), 32'd2);
        pop_expect("t3_pop0", 4'd5);
        pop_expect("t3_pop1", 4'd7);

        // Fill to DEPTH, drop the fifth, then push-with-pop while full.
        for (int i = 1; i <= 5; i++) begin
            hold(4'd0, 4);
            hold(4'(i), 4);
        end
        hold(4'd0, 1);
        check("t4_full_count", 32'(fifo_count), 32'd4);
        check("t4_overflow", 32'(overflow), 32'd1);
        hold(4'd0, 3);
        hold(4'd6, 4);
        sign_in = 4'd0;
        pop_expect("t4_popfull", 4'd1);
        check("t4_popfull_count", 32'(fifo_count), 32'd4);
        check("t4_overflow_sticky", 32'(overflow), 32'd1);
        pop_expect("t4_pop2", 4'd2);
        pop_expect("t4_pop3", 4'd3);
        pop_expect("t4_pop4", 4'd4);
        pop_expect("t4_pop6", 4'd6);
        check("t4_empty", 32'(fifo_count), 32'd0);

        // Dropping enable mid-sign returns to IDLE and keeps the queue.
        hold(4'd0, 4);
        hold(4'd7, 4);
        hold(4'd0, 4);
        hold(4'd8, 4);
        hold(4'd0, 5);
        hold(4'd4, 2);
        enable = 1'b0;
        cyc(1);
        check("t5_disable_count", 32'(fifo_count), 32'd2);
        enable = 1'b1;
        hold(4'd4, 8);
        check("t5_no_commit", 32'(fifo_count), 32'd2);
        pop_expect("t5_pop7", 4'd7);
        pop_expect("t5_pop8", 4'd8);
        check("t5_empty", 32'(fifo_count), 32'd0);
        hold(4'd0, 4);
        hold(4'd1, 4);
        hold(4'd0, 4);
        hold(4'd2, 4);
        hold(4'd0, 1);
        check("t5_queued", 32'(fifo_count), 32'd2);
        pop_expect("t5_drain1", 4'd1);
        check("t5_middrain", 32'(fifo_count), 32'd1);
        rst = 1'b1;
        cyc(1);
        check_reset_outputs("t5_rst");
        rst = 1'b0;
        sign_in = 4'd0;

`ifdef SIGN_ENTRY_TIMEOUT_EN
        // Two queued symbols, then no commits: flush at the 32nd cycle after the last commit.
        hold(4'd0, 4);
        hold(4'd1, 4);
        hold(4'd0, 4);
        hold(4'd2, 4);
        hold(4'd0, 1);
        check("t6_queued", 32'(fifo_count), 32'd2);
        cyc(31);
        check("t6_pre_pulse", 32'(timeout_pulse), 32'd0);
        check("t6_pre_count", 32'(fifo_count), 32'd2);
        cyc(1);
        check("t6_pulse", 32'(timeout_pulse), 32'd1);
        check("t6_flushed", 32'(fifo_count), 32'd0);
        check("t6_state", 32'(dut.state), 32'(WAIT_SIGN));
        check("t6_ovf", 32'(overflow), 32'd0);
        cyc(1);
        check("t6_pulse_end", 32'(timeout_pulse), 32'd0);
`else
        hold(4'd0, 40);
        check("no_timeout_pulse", 32'(timeout_pulse), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
